// File: rtl/hc_sr04_pkg.sv
// Shared HC-SR04 definitions: responder state encodings and default protocol timing,
// common to the responder and the ranging controller.
package hc_sr04_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG    = 3'd1,
    S_BURST   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } resp_state_t;

  localparam int unsigned TRIG_MIN_US_DEF     = 10;
  localparam int unsigned BURST_US_DEF        = 200;
  localparam int unsigned ECHO_TIMEOUT_US_DEF = 38000;
  localparam int unsigned HOLDOFF_US_DEF      = 10000;
  localparam int unsigned US_PER_CM           = 58;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hc_sr04_resp_timer.sv
// Saturating strobe-gated time counter with synchronous clear.
module hc_sr04_resp_timer #(
  parameter int unsigned DELAY_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   strobe,
  output logic [DELAY_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (strobe && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hc_sr04_responder.sv
// HC-SR04 sensor emulator: validates the trigger pulse, waits the burst delay,
// then drives echo for range_in strobe_sm units followed by a hold-off.
module hc_sr04_responder
  import hc_sr04_pkg::*;
#(
  parameter int unsigned TRIG_MIN_US     = TRIG_MIN_US_DEF,
  parameter int unsigned BURST_US        = BURST_US_DEF,
  parameter int unsigned ECHO_TIMEOUT_US = ECHO_TIMEOUT_US_DEF,
  parameter int unsigned HOLDOFF_US      = HOLDOFF_US_DEF,
  parameter int unsigned RANGE_WIDTH     = 16,
  parameter int unsigned DELAY_WIDTH     =
    $clog2(max4(TRIG_MIN_US, BURST_US, ECHO_TIMEOUT_US, HOLDOFF_US)) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   strobe_us,
  input  logic                   strobe_sm,
  input  logic                   trigger,
  input  logic [RANGE_WIDTH-1:0] range_in,
  output logic                   echo,
  output logic                   busy,
  output logic                   short_trig
);

  localparam logic [DELAY_WIDTH-1:0] TRIG_MIN_D = DELAY_WIDTH'(TRIG_MIN_US);
  localparam logic [DELAY_WIDTH-1:0] BURST_D    = DELAY_WIDTH'(BURST_US);
  localparam logic [DELAY_WIDTH-1:0] ECHO_TO_D  = DELAY_WIDTH'(ECHO_TIMEOUT_US);
  localparam logic [DELAY_WIDTH-1:0] HOLDOFF_D  = DELAY_WIDTH'(HOLDOFF_US);

  resp_state_t            state, next_state;
  logic [DELAY_WIDTH-1:0] delay;
  logic [RANGE_WIDTH-1:0] range_q;
  logic                   state_change;
  logic                   capture;
  logic                   short_det;

  // Clearing on the transition edge makes delay read 0 in the first cycle of every state.
  assign state_change = (next_state != state);

  hc_sr04_resp_timer #(
    .DELAY_WIDTH(DELAY_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_change),
    .strobe (strobe_us),
    .count  (delay)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    short_det  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) next_state = S_TRIG;
      end
      S_TRIG: begin
        if (!trigger) begin
          if (delay >= TRIG_MIN_D) begin
            next_state = S_BURST;
            capture    = 1'b1;
          end else begin
            next_state = S_IDLE;
            short_det  = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (delay == BURST_D) next_state = (range_q != '0) ? S_ECHO : S_HOLDOFF;
      end
      S_ECHO: begin
        // Timeout takes priority over a coincident final strobe_sm.
        if (delay == ECHO_TO_D) begin
          next_state = S_HOLDOFF;
        end else if (strobe_sm && (range_q == RANGE_WIDTH'(1))) begin
          next_state = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (delay == HOLDOFF_D) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    echo = (state == S_ECHO);
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q <= '0;
    end else if (capture) begin
      range_q <= range_in;
    end else if ((state == S_ECHO) && strobe_sm) begin
      range_q <= range_q - RANGE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_trig <= 1'b0;
    end else begin
      short_trig <= short_det;
    end
  end

endmodule

// File: doc/hc_sr04_responder.md
Name: hc_sr04_responder

Overview:
- Emulates the HC-SR04 ultrasonic sensor: the device end of the trigger/echo protocol.
- Watches `trigger` and validates the pulse width.
- After a fixed burst delay, drives `echo` high for exactly `range_in` units of `strobe_sm`, then enforces a hold-off.
- Used in benches and on-board loopback, so the ranging controller can be exercised without a physical sensor.

Parameters:
- TRIG_MIN_US, 10, minimum trigger high time in strobe_us ticks for a valid trigger.
- BURST_US, 200, delay between trigger fall and echo rise, in strobe_us ticks.
- ECHO_TIMEOUT_US, 38000, maximum echo high time in strobe_us ticks; longer echoes are truncated.
- HOLDOFF_US, 10000, dead time after echo fall before a new trigger is accepted.
- RANGE_WIDTH, 16, width of range_in and of the internal range counter.
- DELAY_WIDTH, $clog2(max of all *_US)+1, width of the time counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- strobe_us  in  1  one-cycle pulse, once per microsecond.
- strobe_sm  in  1  one-cycle pulse, once per range unit (58 us/cm).
- trigger  in  1  trigger from the controller; same clock domain, sampled directly.
- range_in  in  RANGE_WIDTH  emulated distance in strobe_sm units; captured at trigger fall.
- echo  out  1  echo pulse to the controller.
- busy  out  1  high whenever state != S_IDLE.
- short_trig  out  1  one-cycle pulse on rejection of a trigger shorter than TRIG_MIN_US.

Behaviour:
- Reset values: state=S_IDLE, delay=0, range_q=0; echo, busy and short_trig all 0.
- Time counter `delay`:
  - cleared to 0 in the cycle after any state change, regardless of strobe_us;
  - otherwise increments on strobe_us;
  - saturates at all-ones.
- States and transitions, evaluated every clk:
  - S_IDLE: trigger=1 -> S_TRIG.
  - S_TRIG, trigger=0 and delay>=TRIG_MIN_US: capture range_in into range_q; go to S_BURST.
  - S_TRIG, trigger=0 and delay<TRIG_MIN_US: go to S_IDLE; short_trig=1 for exactly that one transition cycle (registered, visible the next cycle).
  - S_BURST: when delay==BURST_US -> S_ECHO if range_q!=0, else -> S_HOLDOFF (zero range gives no echo pulse).
  - S_ECHO: on strobe_sm, range_q decrements. When strobe_sm=1 and range_q==1 -> S_HOLDOFF.
  - S_ECHO timeout: delay==ECHO_TIMEOUT_US -> S_HOLDOFF. Timeout wins over a simultaneous strobe_sm.
  - S_HOLDOFF: delay==HOLDOFF_US -> S_IDLE.
- Trigger edges during S_BURST/S_ECHO/S_HOLDOFF are ignored.
- A trigger still high on return to S_IDLE enters S_TRIG immediately; its width is measured from that point.
- echo = (state==S_ECHO); Moore output from the state register, glitch-free.
  - Rises 1 clk after the BURST exit condition.
  - Falls 1 clk after the range_q-th strobe_sm seen in S_ECHO.
- Number of strobe_sm pulses sampled while echo=1 equals range_in (if not timed out).
- range_in changes after capture do not affect the current measurement.
- Asserting rst mid-operation drops echo in the same cycle (asynchronous) and returns to S_IDLE.
- State encoding: 3 bits; unused codes go to S_IDLE.

Decomposition:
- Shared package hc_sr04_pkg holds:
  - the responder state encodings S_IDLE..S_HOLDOFF;
  - the default timing constants (trigger 10 us, echo timeout 38000 us, 58 us/cm), shared with the ranging controller so both ends agree.
- One natural sub-module, hc_sr04_resp_timer: saturating strobe-gated counter with synchronous clear, parameterised by DELAY_WIDTH.

Test Plan:
Bench parameters: TRIG_MIN_US=10, BURST_US=4, ECHO_TIMEOUT_US=100, HOLDOFF_US=20; strobe_us every clk; strobe_sm every 3rd clk.
- Valid trigger: trigger high 12 clk, range_in=5 -> echo rises 6 clk after trigger fall; exactly 5 strobe_sm seen while echo=1; busy falls about 21 clk after echo fall.
- Short trigger: trigger high 5 clk -> short_trig pulses once for 1 clk; echo stays 0; busy returns 0.
- Zero range: valid trigger, range_in=0 -> echo never rises; S_HOLDOFF entered; busy held 21 clk past burst.
- Timeout: range_in=60 (180 clk > 100) -> echo high exactly 101 clk, then falls; fewer than 60 strobe_sm seen.
- Retrigger and reset: second trigger during echo is ignored and range_in change after capture has no effect; rst asserted mid-echo -> echo=0 immediately, state S_IDLE, next valid trigger behaves as in the valid-trigger case.
